// File: rtl/tri_pkg.sv
// Shared types, widths, FSM state codes and helpers for the triangle raster scanner.
// Contents: coordinate/count widths, clip window, edge-function widths,
// state constants, vertex/triangle payload structs, min3/max3, edge_fn.
package tri_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned CNT_W    = 2 * COORD_W;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Edge function widths: signed differences, exact products, exact sum.
    localparam int unsigned DIFF_W = COORD_W + 1;
    localparam int unsigned PROD_W = 2 * COORD_W + 2;
    localparam int unsigned EDGE_W = 2 * COORD_W + 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef struct packed {
        vertex_t a;
        vertex_t b;
        vertex_t c;
    } tri_t;

    function automatic coord_t min3(coord_t p, coord_t q, coord_t r);
        coord_t m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic coord_t max3(coord_t p, coord_t q, coord_t r);
        coord_t m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    // (p1-p0) x (pt-p0): positive on one side of p0->p1, zero on the line.
    function automatic logic signed [EDGE_W-1:0] edge_fn(vertex_t p0, vertex_t p1,
                                                         coord_t px, coord_t py);
        logic signed [DIFF_W-1:0] dx01;
        logic signed [DIFF_W-1:0] dy01;
        logic signed [DIFF_W-1:0] dxp;
        logic signed [DIFF_W-1:0] dyp;
        logic signed [PROD_W-1:0] m0;
        logic signed [PROD_W-1:0] m1;
        dx01 = $signed({1'b0, p1.x}) - $signed({1'b0, p0.x});
        dy01 = $signed({1'b0, p1.y}) - $signed({1'b0, p0.y});
        dxp  = $signed({1'b0, px})   - $signed({1'b0, p0.x});
        dyp  = $signed({1'b0, py})   - $signed({1'b0, p0.y});
        m0 = PROD_W'(dx01) * PROD_W'(dyp);
        m1 = PROD_W'(dy01) * PROD_W'(dxp);
        return EDGE_W'(m0) - EDGE_W'(m1);
    endfunction

endpackage

// File: rtl/tri_raster_scan_if.sv
// Triangle-in / pixel-out bus of the raster scanner.
// slave  : scanner view (takes triangles, produces pixels, done, pix_count)
// master : source/sink view (offers triangles, accepts pixels)
interface tri_raster_scan_if;
    import tri_pkg::*;

    logic               in_valid;
    logic               in_ready;
    coord_t             ax;
    coord_t             ay;
    coord_t             bx;
    coord_t             by;
    coord_t             cx;
    coord_t             cy;
    logic               pix_valid;
    logic               pix_ready;
    coord_t             pix_x;
    coord_t             pix_y;
    logic               done;
    logic [CNT_W-1:0]   pix_count;

    modport slave (
        input  in_valid, ax, ay, bx, by, cx, cy, pix_ready,
        output in_ready, pix_valid, pix_x, pix_y, done, pix_count
    );

    modport master (
        output in_valid, ax, ay, bx, by, cx, cy, pix_ready,
        input  in_ready, pix_valid, pix_x, pix_y, done, pix_count
    );

endinterface

// File: rtl/tri_edge_test.sv
// Point-in-triangle test: three edge functions, covered when all share a sign
// (zero counts as either sign, so edges and vertices are inside for both windings).
// Ports: tri_v (triangle), sx/sy (candidate point), covered_c (combinational result).
module tri_edge_test
    import tri_pkg::*;
(
    input  tri_t   tri_v,
    input  coord_t sx,
    input  coord_t sy,
    output logic   covered_c
);

    logic signed [EDGE_W-1:0] e_ab;
    logic signed [EDGE_W-1:0] e_bc;
    logic signed [EDGE_W-1:0] e_ca;
    logic                     nonneg;
    logic                     nonpos;

    always_comb begin
        e_ab = edge_fn(tri_v.a, tri_v.b, sx, sy);
        e_bc = edge_fn(tri_v.b, tri_v.c, sx, sy);
        e_ca = edge_fn(tri_v.c, tri_v.a, sx, sy);
        nonneg = !e_ab[EDGE_W-1] && !e_bc[EDGE_W-1] && !e_ca[EDGE_W-1];
        nonpos = (e_ab[EDGE_W-1] || (e_ab == '0)) &&
                 (e_bc[EDGE_W-1] || (e_bc == '0)) &&
                 (e_ca[EDGE_W-1] || (e_ca == '0));
        covered_c = nonneg || nonpos;
    end

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle raster scanner: accepts one triangle, sweeps its bounding box one
// candidate per cycle (x inner, y outer) and streams covered pixels with valid/ready.
// Ports: clk, rst_n (async active-low), bus (tri_raster_scan_if.slave).
// Optional macro TRI_CLIP_EN: clips the bbox max corner to SCREEN_W-1 / SCREEN_H-1.
module tri_raster_scan
    import tri_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    tri_raster_scan_if.slave    bus
);

    logic [1:0]         state_q, state_d;
    tri_t               tri_q, tri_d;
    coord_t             xmin_q, xmin_d, xmax_q, xmax_d;
    coord_t             ymin_q, ymin_d, ymax_q, ymax_d;
    coord_t             sx_q, sx_d, sy_q, sy_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pix_valid_q;
    logic               done_q;
    logic               in_ready_q;

    coord_t                     bb_xmin_c, bb_xmax_c, bb_ymin_c, bb_ymax_c;
    logic                       bb_empty_c;
    logic signed [EDGE_W-1:0]   area2_c;
    logic                       advance_c;
    logic                       cov_next_c;

    // Bounding box and doubled signed area, consumed in SETUP.
    always_comb begin
        bb_xmin_c = min3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        bb_ymin_c = min3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
        bb_xmax_c = max3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        bb_ymax_c = max3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
`ifdef TRI_CLIP_EN
        if (bb_xmax_c > COORD_W'(SCREEN_W - 1)) bb_xmax_c = COORD_W'(SCREEN_W - 1);
        if (bb_ymax_c > COORD_W'(SCREEN_H - 1)) bb_ymax_c = COORD_W'(SCREEN_H - 1);
        bb_empty_c = (bb_xmin_c > bb_xmax_c) || (bb_ymin_c > bb_ymax_c);
`else
        bb_empty_c = 1'b0;
`endif
        area2_c = edge_fn(tri_q.a, tri_q.b, tri_q.c.x, tri_q.c.y);
    end

    // An uncovered candidate moves on unconditionally; a covered one waits for pix_ready.
    assign advance_c = !pix_valid_q || bus.pix_ready;

    // Next-state, scan counter and pixel counter logic.
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_SETUP;
                    tri_d   = '{a: '{x: bus.ax, y: bus.ay},
                                b: '{x: bus.bx, y: bus.by},
                                c: '{x: bus.cx, y: bus.cy}};
                    count_d = '0;
                end
            end
            ST_SETUP: begin
                xmin_d = bb_xmin_c;
                xmax_d = bb_xmax_c;
                ymin_d = bb_ymin_c;
                ymax_d = bb_ymax_c;
                sx_d   = bb_xmin_c;
                sy_d   = bb_ymin_c;
                if ((area2_c == '0) || bb_empty_c) state_d = ST_DONE;
                else                               state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (advance_c) begin
                    if (pix_valid_q) count_d = count_q + CNT_W'(1);
                    // Compare before incrementing so a max of 2^COORD_W-1 never wraps.
                    if (sx_q == xmax_q) begin
                        if (sy_q == ymax_q) begin
                            state_d = ST_DONE;
                        end else begin
                            sx_d = xmin_q;
                            sy_d = sy_q + COORD_W'(1);
                        end
                    end else begin
                        sx_d = sx_q + COORD_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Coverage of the candidate presented next cycle, so pix_valid can be a flop.
    tri_edge_test u_edge (
        .tri_v     (tri_q),
        .sx        (sx_d),
        .sy        (sy_d),
        .covered_c (cov_next_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tri_q       <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            count_q     <= '0;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            tri_q       <= tri_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            count_q     <= count_d;
            pix_valid_q <= (state_d == ST_SCAN) && cov_next_c;
            done_q      <= (state_d == ST_DONE);
            in_ready_q  <= (state_d == ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = sx_q;
    assign bus.pix_y     = sy_q;
    assign bus.done      = done_q;
    assign bus.pix_count = count_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Self-checking bench for tri_raster_scan: directed and random triangles compared
// against a point-by-point coverage model built from plain integer arithmetic.
module tb_tri_raster_scan;
    import tri_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri_raster_scan_if bus();

    tri_raster_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int exp_x[$];
    int exp_y[$];
    int m_ncand;
    bit m_first_cov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint efn(longint x0, longint y0, longint x1, longint y1,
                                   longint px, longint py);
        return (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    endfunction

    function automatic int imin(int p, int q);
        return (p < q) ? p : q;
    endfunction

    function automatic int imax(int p, int q);
        return (p > q) ? p : q;
    endfunction

    // Reference: every lattice point of the bbox whose three edge values share a sign.
    task automatic build_model(input int ax, input int ay, input int bx, input int by,
                               input int cx, input int cy);
        int xmin, xmax, ymin, ymax;
        longint e0, e1, e2;
        exp_x.delete();
        exp_y.delete();
        m_ncand = 0;
        m_first_cov = 1'b0;
        xmin = imin(ax, imin(bx, cx));
        xmax = imax(ax, imax(bx, cx));
        ymin = imin(ay, imin(by, cy));
        ymax = imax(ay, imax(by, cy));
        if (efn(ax, ay, bx, by, cx, cy) == 0) return;
`ifdef TRI_CLIP_EN
        xmax = imin(xmax, int'(SCREEN_W) - 1);
        ymax = imin(ymax, int'(SCREEN_H) - 1);
        if (xmin > xmax || ymin > ymax) return;
`endif
        m_ncand = (xmax - xmin + 1) * (ymax - ymin + 1);
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                e0 = efn(ax, ay, bx, by, x, y);
                e1 = efn(bx, by, cx, cy, x, y);
                e2 = efn(cx, cy, ax, ay, x, y);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                    if (x == xmin && y == ymin) m_first_cov = 1'b1;
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            end
        end
    endtask

    // Present a triangle at a negedge in IDLE; returns at the negedge of the SETUP cycle.
    task automatic offer(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
        bus.ax = COORD_W'(ax);
        bus.ay = COORD_W'(ay);
        bus.bx = COORD_W'(bx);
        bus.by = COORD_W'(by);
        bus.cx = COORD_W'(cx);
        bus.cy = COORD_W'(cy);
        bus.in_valid = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_setup", 32'(bus.in_ready), 32'd0);
        check("pix_valid_setup", 32'(bus.pix_valid), 32'd0);
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall at first pixel,
    // 3: always ready with a junk triangle offered throughout the scan.
    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int mode);
        int got = 0;
        int cyc = 0;
        int nstall = 0;
        int first_stall = 0;
        bit done_seen = 1'b0;
        bit stalled_prev = 1'b0;
        bit rdy;
        build_model(ax, ay, bx, by, cx, cy);
        offer(ax, ay, bx, by, cx, cy);
        while (!done_seen && cyc < 20000) begin
            if (mode == 3) begin
                bus.in_valid = 1'b1;
                bus.ax = COORD_W'($urandom_range(0, 100));
                bus.cy = COORD_W'($urandom_range(0, 100));
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1 && m_ncand != 0)
                check("first_candidate_valid", 32'(bus.pix_valid), 32'(m_first_cov));
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                bus.in_valid = 1'b0;
                check("pixels_seen", 32'(got), 32'(exp_x.size()));
                check("pix_count_done", 32'(bus.pix_count), 32'(exp_x.size()));
                check("done_cycle", 32'(cyc), 32'(1 + m_ncand + nstall));
                check("pix_valid_done", 32'(bus.pix_valid), 32'd0);
            end else begin
                if (stalled_prev) check("hold_valid", 32'(bus.pix_valid), 32'd1);
                if (bus.pix_valid === 1'b1) begin
                    case (mode)
                        1: rdy = ($urandom_range(0, 2) != 0);
                        2: begin
                            rdy = !(got == 0 && first_stall < 3);
                            if (!rdy) first_stall++;
                        end
                        default: rdy = 1'b1;
                    endcase
                    bus.pix_ready = rdy;
                    if (got < exp_x.size()) begin
                        check("pix_x", 32'(bus.pix_x), 32'(exp_x[got]));
                        check("pix_y", 32'(bus.pix_y), 32'(exp_y[got]));
                    end else begin
                        check("extra_pixel", 32'(got), 32'(exp_x.size() - 1));
                    end
                    if (rdy) got++;
                    else nstall++;
                    stalled_prev = !rdy;
                end else begin
                    bus.pix_ready = 1'($urandom_range(0, 1));
                    stalled_prev = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("done_before_timeout", 32'(done_seen), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("in_ready_after_done", 32'(bus.in_ready), 32'd1);
        check("pix_count_held", 32'(bus.pix_count), 32'(exp_x.size()));
    endtask

    initial begin
        int bx0, by0;
        bus.in_valid  = 1'b0;
        bus.pix_ready = 1'b0;
        bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pix_x", 32'(bus.pix_x), 32'd0);
        check("rst_pix_y", 32'(bus.pix_y), 32'd0);
        check("rst_pix_count", 32'(bus.pix_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic right triangle and its reversed winding.
        run_tri(0, 0, 4, 0, 0, 4, 0);
        check("basic_count_15", 32'(bus.pix_count), 32'd15);
        run_tri(0, 0, 0, 4, 4, 0, 0);
        check("reversed_count_15", 32'(bus.pix_count), 32'd15);

        // Degenerate: collinear and coincident vertices.
        run_tri(0, 0, 2, 2, 4, 4, 0);
        check("collinear_count_0", 32'(bus.pix_count), 32'd0);
        run_tri(5, 5, 5, 5, 5, 5, 0);
        check("coincident_count_0", 32'(bus.pix_count), 32'd0);

        // Backpressure at the first pixel.
        run_tri(0, 0, 4, 0, 0, 4, 2);
        check("stall_count_15", 32'(bus.pix_count), 32'd15);

        // Top corner of the coordinate plane.
        run_tri(2040, 2040, 2047, 2040, 2040, 2047, 0);
`ifndef TRI_CLIP_EN
        check("corner_count_36", 32'(bus.pix_count), 32'd36);
`endif

        // Clip-window triangles (expected values follow the build configuration).
        run_tri(600, 0, 700, 0, 600, 100, 0);
        run_tri(700, 500, 710, 500, 700, 510, 0);

        // New triangle offered during the scan must be ignored.
        run_tri(3, 1, 9, 4, 1, 8, 3);

        // Random triangles with random backpressure.
        for (int i = 0; i < 10; i++) begin
            bx0 = (i == 9) ? 2047 - 20 : int'($urandom_range(0, 2000));
            by0 = (i == 9) ? 2047 - 20 : int'($urandom_range(0, 2000));
            run_tri(bx0 + int'($urandom_range(0, 20)), by0 + int'($urandom_range(0, 20)),
                    bx0 + int'($urandom_range(0, 20)), by0 + int'($urandom_range(0, 20)),
                    bx0 + int'($urandom_range(0, 20)), by0 + int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 1)));
        end

        // Reset in the middle of a scan.
        bus.pix_ready = 1'b1;
        offer(0, 0, 8, 0, 0, 8);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_pix_count", 32'(bus.pix_count), 32'd0);
        check("midrst_pix_x", 32'(bus.pix_x), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_tri(0, 0, 4, 0, 0, 4, 1);
        check("post_rst_count_15", 32'(bus.pix_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
